// File: rtl/read_burst_controller.sv
// Register-read burst responder between the UART packet receiver and transmitter.
// Optional macro READ_BURST_DROP_COUNT_EN adds a saturating dropped-request counter.
package read_burst_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

endpackage

module read_burst_controller
    import read_burst_pkg::*;
#(
    parameter int unsigned DATA_BYTES   = 4,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 8,
    parameter logic [7:0]  LOCAL_ADDR   = 8'h00
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  UART_PACKET              ipRxStream,
    input  logic                    ipTxReady,
    input  logic [8*DATA_BYTES-1:0] ipReadData,
    output logic [ADDR_W-1:0]       opReadAddress,
    output UART_PACKET              opTxStream,
    output logic                    opBusy
`ifdef READ_BURST_DROP_COUNT_EN
    ,
    output logic [7:0]              opDropCount
`endif
);

    localparam int unsigned DW     = 8 * DATA_BYTES;
    localparam logic [7:0]  LAST_B = 8'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GET_COUNT,
        READ_WAIT,
        SEND
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    UART_PACKET        tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [7:0]        req_q, req_d;
    logic [7:0]        words_q, words_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [7:0]        bcnt_q, bcnt_d;
    logic [2:0]        lat_q, lat_d;
    logic              got_q, got_d;
    logic              armed_q, armed_d;
    logic [DW-1:0]     shift_q, shift_d;

    logic              req_hit;
    logic              last_b;
    logic              last_w;
    logic [7:0]        n_sel;

    function automatic logic [7:0] clamp_n(input logic [7:0] b);
        if (b == 8'd0) begin
            return 8'd1;
        end else if (b > 8'(MAX_BURST)) begin
            return 8'(MAX_BURST);
        end
        return b;
    endfunction

    function automatic logic [7:0] pkt_len(input logic [7:0] n);
        logic [15:0] p;
        p = 16'(n) * 16'(DATA_BYTES);
        return p[7:0];
    endfunction

    assign req_hit = ipRxStream.Valid && ipRxStream.SoP &&
                     (ipRxStream.Destination == LOCAL_ADDR);
    assign last_b  = (bcnt_q == LAST_B);
    assign last_w  = (wcnt_q == words_q - 8'd1);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        req_d    = req_q;
        words_d  = words_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        lat_d    = lat_q;
        got_d    = got_q;
        shift_d  = shift_q;
        n_sel    = words_q;
        // Ready low anywhere re-arms; one emit per ready-high episode.
        armed_d  = armed_q | ~ipTxReady;
        tx_d.Valid = 1'b0;
        tx_d.SoP   = 1'b0;
        tx_d.EoP   = 1'b0;

        case (state_q)
            IDLE: begin
                wcnt_d = 8'd0;
                bcnt_d = 8'd0;
                lat_d  = 3'd0;
                got_d  = 1'b0;
                if (req_hit) begin
                    addr_d  = ipRxStream.Data[ADDR_W-1:0];
                    req_d   = ipRxStream.Source;
                    busy_d  = 1'b1;
                    words_d = 8'd1;
                    if (ipRxStream.Length == 8'd1 && ipRxStream.EoP) begin
                        state_d          = READ_WAIT;
                        tx_d.Source      = LOCAL_ADDR;
                        tx_d.Destination = ipRxStream.Source;
                        tx_d.Length      = pkt_len(8'd1);
                    end else begin
                        state_d = GET_COUNT;
                    end
                end
            end

            GET_COUNT: begin
                if (ipRxStream.Valid) begin
                    if (!got_q) begin
                        n_sel   = clamp_n(ipRxStream.Data);
                        words_d = n_sel;
                        got_d   = 1'b1;
                    end
                    if (ipRxStream.EoP) begin
                        state_d          = READ_WAIT;
                        tx_d.Source      = LOCAL_ADDR;
                        tx_d.Destination = req_q;
                        tx_d.Length      = pkt_len(n_sel);
                    end
                end
            end

            READ_WAIT: begin
                if (lat_q == 3'(READ_LATENCY)) begin
                    shift_d = ipReadData;
                    lat_d   = 3'd0;
                    state_d = SEND;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end

            SEND: begin
                if (ipTxReady && armed_q) begin
                    armed_d    = 1'b0;
                    tx_d.Valid = 1'b1;
                    tx_d.Data  = shift_q[DW-1 -: 8];
                    tx_d.SoP   = (wcnt_q == 8'd0) && (bcnt_q == 8'd0);
                    tx_d.EoP   = last_b && last_w;
                    shift_d    = shift_q << 8;
                    if (last_b) begin
                        bcnt_d = 8'd0;
                        if (last_w) begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            wcnt_d  = wcnt_q + 8'd1;
                            state_d = READ_WAIT;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tx_q    <= '0;
            busy_q  <= 1'b0;
            req_q   <= 8'd0;
            words_q <= 8'd0;
            wcnt_q  <= 8'd0;
            bcnt_q  <= 8'd0;
            lat_q   <= 3'd0;
            got_q   <= 1'b0;
            armed_q <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            words_q <= words_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            lat_q   <= lat_d;
            got_q   <= got_d;
            armed_q <= armed_d;
            shift_q <= shift_d;
        end
    end

    assign opReadAddress = addr_q;
    assign opTxStream    = tx_q;
    assign opBusy        = busy_q;

`ifdef READ_BURST_DROP_COUNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (busy_q && req_hit && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign opDropCount = drop_q;
`endif

endmodule

// File: tb/tb_read_burst_controller.sv
// Bench for read_burst_controller: packet-level response model plus directed
// requests covering single read, wrap burst, clamp, handshake, drop and reset.
module tb_read_burst_controller;
    import read_burst_pkg::*;

    localparam int MAXB  = 8;
    localparam int LOCAL = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tog = 1'b0;
    logic        tog_r = 1'b0;
    logic        man_r = 1'b1;
    logic        rdy;
    UART_PACKET  rx;
    UART_PACKET  tx;
    logic [31:0] rdata;
    logic [7:0]  raddr;
    logic        busy;
`ifdef READ_BURST_DROP_COUNT_EN
    logic [7:0]  drops;
`endif

    always #5 clk = ~clk;

    assign rdy = tog ? tog_r : man_r;

    always @(posedge clk) begin
        #1;
        tog_r = ~tog_r;
    end

    read_burst_controller dut (
        .ipClk         (clk),
        .ipReset       (rst_n),
        .ipRxStream    (rx),
        .ipTxReady     (rdy),
        .ipReadData    (rdata),
        .opReadAddress (raddr),
        .opTxStream    (tx),
        .opBusy        (busy)
`ifdef READ_BURST_DROP_COUNT_EN
        ,
        .opDropCount   (drops)
`endif
    );

    logic [31:0] regs [256];
    logic [31:0] rd_pipe = 32'h0;

    always @(posedge clk) rd_pipe <= regs[raddr];
    assign rdata = rd_pipe;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [7:0] len;
        logic [7:0] dst;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] gotq[$];
    logic [7:0] alog[$];
    logic [7:0] aprev = 8'h0;
    bit         alog_en = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         eop_seen = 0;
    int         vcount = 0;
    logic [7:0] last_len = 8'h0;
    logic [7:0] last_dst = 8'h0;
    bit         arm_ok = 1'b0;
    bit         rdy_k = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_resp(input logic [7:0] src, input logic [7:0] addr,
                               input logic [7:0] cnt, input bit has_cnt);
        int   n;
        exp_t e;
        logic [31:0] w;
        n = has_cnt ? int'(cnt) : 1;
        if (n == 0) n = 1;
        if (n > MAXB) n = MAXB;
        for (int k = 0; k < n; k++) begin
            w = regs[8'(int'(addr) + k)];
            for (int b = 0; b < 4; b++) begin
                e.d   = w[31-8*b -: 8];
                e.sop = (k == 0 && b == 0);
                e.eop = (k == n - 1 && b == 3);
                e.len = 8'(n * 4);
                e.dst = src;
                expq.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            arm_ok = 1'b0;
            rdy_k  = rdy;
        end else begin
            if (tx.Valid) begin
                vcount++;
                chk("emit_after_ready_low", {30'h0, arm_ok, rdy_k}, 32'h3);
                gotq.push_back(tx.Data);
                last_len = tx.Length;
                last_dst = tx.Destination;
                if (tx.EoP) eop_seen++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %h required none",
                             tx.Data);
                end else begin
                    e = expq.pop_front();
                    chk("data", 32'(tx.Data), 32'(e.d));
                    chk("sop", 32'(tx.SoP), 32'(e.sop));
                    chk("eop", 32'(tx.EoP), 32'(e.eop));
                    chk("length", 32'(tx.Length), 32'(e.len));
                    chk("dest", 32'(tx.Destination), 32'(e.dst));
                    chk("source", 32'(tx.Source), 32'(LOCAL));
                    chk("busy_on_emit", 32'(busy), 32'(!e.eop));
                end
            end
            arm_ok = tx.Valid ? 1'b0 : (arm_ok | !rdy_k);
            rdy_k  = rdy;
            if (alog_en && raddr != aprev) alog.push_back(raddr);
            aprev = raddr;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] len, input logic [7:0] b0,
                            input logic [7:0] b1, input int nb);
        for (int i = 0; i < nb; i++) begin
            rx.Source      = src;
            rx.Destination = dst;
            rx.Length      = len;
            rx.Data        = (i == 0) ? b0 : b1;
            rx.SoP         = (i == 0);
            rx.EoP         = (i == nb - 1);
            rx.Valid       = 1'b1;
            cyc(1);
        end
        rx = '0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((expq.size() != 0 || busy) && t < 3000) begin
            cyc(1);
            t++;
        end
        chk("done_in_time", 32'(t < 3000), 32'h1);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 256; i++) begin
            regs[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5a, 8'hc3};
        end
        regs[8'h10] = 32'h11223344;
        regs[8'hfe] = 32'hA0A1A2A3;
        regs[8'hff] = 32'hB0B1B2B3;
        regs[8'h00] = 32'hC0C1C2C3;
        rx = '0;

        cyc(3);
        chk("reset_tx", 32'(tx == '0), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_addr", 32'(raddr), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // single read
        tog = 1'b1;
        gotq.delete();
        expect_resp(8'h5a, 8'h10, 8'h0, 1'b0);
        send_pkt(8'h5a, 8'h00, 8'd1, 8'h10, 8'h0, 1);
        chk("busy_after_req", 32'(busy), 32'h1);
        wait_done();
        chk("single_count", 32'(gotq.size()), 32'd4);
        if (gotq.size() == 4)
            chk("single_bytes", {gotq[0], gotq[1], gotq[2], gotq[3]},
                32'h11223344);
        chk("single_len", 32'(last_len), 32'h04);
        chk("single_dst", 32'(last_dst), 32'h5a);
        chk("single_busy_end", 32'(busy), 32'h0);

        // wrapping burst
        gotq.delete();
        alog.delete();
        eop_seen = 0;
        aprev = raddr;
        alog_en = 1'b1;
        expect_resp(8'h33, 8'hfe, 8'd3, 1'b1);
        send_pkt(8'h33, 8'h00, 8'd2, 8'hfe, 8'd3, 2);
        wait_done();
        alog_en = 1'b0;
        chk("burst_addr_count", 32'(alog.size()), 32'd3);
        if (alog.size() == 3)
            chk("burst_addr_seq", {8'h0, alog[0], alog[1], alog[2]},
                32'h00feff00);
        chk("burst_count", 32'(gotq.size()), 32'd12);
        if (gotq.size() == 12)
            chk("burst_firsts", {8'h0, gotq[0], gotq[4], gotq[8]},
                32'h00a0b0c0);
        chk("burst_len", 32'(last_len), 32'h0c);
        chk("burst_one_eop", 32'(eop_seen), 32'd1);

        // clamp and zero count
        gotq.delete();
        expect_resp(8'h44, 8'h20, 8'd20, 1'b1);
        send_pkt(8'h44, 8'h00, 8'd2, 8'h20, 8'd20, 2);
        wait_done();
        chk("clamp_len", 32'(last_len), 32'h20);
        chk("clamp_count", 32'(gotq.size()), 32'd32);
        gotq.delete();
        expect_resp(8'h44, 8'h30, 8'd0, 1'b1);
        send_pkt(8'h44, 8'h00, 8'd2, 8'h30, 8'd0, 2);
        wait_done();
        chk("zero_len", 32'(last_len), 32'h04);
        chk("zero_count", 32'(gotq.size()), 32'd4);

        // handshake: held-high ready gives one byte
        tog = 1'b0;
        man_r = 1'b0;
        expect_resp(8'h66, 8'h40, 8'h0, 1'b0);
        send_pkt(8'h66, 8'h00, 8'd1, 8'h40, 8'h0, 1);
        vcount = 0;
        man_r = 1'b1;
        cyc(12);
        chk("held_high_one_pulse", 32'(vcount), 32'd1);
        for (int i = 0; i < 3; i++) begin
            man_r = 1'b0;
            cyc(1);
            man_r = 1'b1;
            cyc(3);
        end
        chk("toggle_three_bytes", 32'(vcount), 32'd4);
        wait_done();

        // request while busy is dropped
        tog = 1'b1;
        gotq.delete();
        expect_resp(8'h77, 8'h50, 8'd2, 1'b1);
        send_pkt(8'h77, 8'h00, 8'd2, 8'h50, 8'd2, 2);
        cyc(5);
        send_pkt(8'h88, 8'h00, 8'd2, 8'h60, 8'd1, 2);
        wait_done();
        cyc(40);
        chk("drop_bytes", 32'(gotq.size()), 32'd8);
        chk("drop_idle", 32'(busy), 32'h0);
`ifdef READ_BURST_DROP_COUNT_EN
        chk("drop_count", 32'(drops), 32'd1);
`endif

        // reset mid-burst
        gotq.delete();
        expect_resp(8'h99, 8'h10, 8'h0, 1'b0);
        send_pkt(8'h99, 8'h00, 8'd1, 8'h10, 8'h0, 1);
        t = 0;
        while (gotq.size() < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("two_bytes_before_reset", 32'(gotq.size()), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", 32'(tx == '0), 32'h1);
        chk("midreset_busy", 32'(busy), 32'h0);
        chk("midreset_addr", 32'(raddr), 32'h0);
        expq.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        gotq.delete();
        eop_seen = 0;
        expect_resp(8'h99, 8'h10, 8'h0, 1'b0);
        send_pkt(8'h99, 8'h00, 8'd1, 8'h10, 8'h0, 1);
        wait_done();
        chk("post_reset_count", 32'(gotq.size()), 32'd4);
        if (gotq.size() == 4)
            chk("post_reset_first", 32'(gotq[0]), 32'h11);
        chk("post_reset_eop", 32'(eop_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

endmodule
